// File: rtl/blake_nonce_scan_if.sv
// Handshake bundle between the nonce scanner (master) and one BLAKE-512 hash core (slave).
interface blake_nonce_scan_if;
   logic         hc_ena;
   logic [639:0] hc_din;
   logic         hc_rdy;
   logic [511:0] hc_dout;

   modport master (output hc_ena, hc_din, input hc_rdy, hc_dout);
   modport slave  (input hc_ena, hc_din, output hc_rdy, hc_dout);
endinterface

// File: rtl/blake_nonce_scan.sv
// Nonce scanner: splices successive nonces into a header, launches one hash per nonce,
// and stops on the first digest below target, range exhaustion, abort or core timeout.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start; latches run parameters
// S_ISSUE | one-cycle hc_ena pulse, watchdog cleared
// S_WAIT  | waiting for hc_rdy, watchdog counting
// S_CHECK | compare captured digest with target, pick next nonce or stop
// S_FIN   | one-cycle done pulse
module blake_nonce_scan #(
   parameter int TIMEOUT = 200,
   parameter int CNT_W   = 32
) (
   input  logic               clk,
   input  logic               rstb,
   input  logic               i_start,
   input  logic               i_abort,
   input  logic [639:0]       i_header,
   input  logic [CNT_W-1:0]   i_nonce_start,
   input  logic [CNT_W-1:0]   i_nonce_count,
   input  logic [511:0]       i_target,
   blake_nonce_scan_if.master hc,
   output logic               o_busy,
   output logic               o_done,
   output logic               o_found,
   output logic               o_timeout_err,
   output logic [CNT_W-1:0]   o_nonce_out,
   output logic [511:0]       o_digest_out,
   output logic [CNT_W-1:0]   o_tried
);

   localparam int WD_W = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_CHECK, S_FIN} state_t;

   state_t             r_state;
   state_t             w_next;
   logic [639:CNT_W]   r_hdr;
   logic [511:0]       r_target;
   logic [CNT_W-1:0]   r_nonce;
   logic [CNT_W-1:0]   r_count;
   logic [CNT_W-1:0]   r_tried;
   logic [CNT_W-1:0]   r_nonce_out;
   logic [511:0]       r_digest;
   logic [639:0]       r_din;
   logic [WD_W-1:0]    r_wdog;
   logic               r_found;
   logic               r_tout;
   logic               r_abort_pend;

   logic               w_hit;
   logic               w_last;
   logic               w_tmo;
   logic [CNT_W-1:0]   w_tried_inc;
   logic [CNT_W-1:0]   w_nonce_inc;

   assign w_hit       = (r_digest < r_target);
   assign w_tried_inc = r_tried + 1'b1;
   assign w_nonce_inc = r_nonce + 1'b1;
   assign w_last      = (w_tried_inc == r_count);
   assign w_tmo       = (r_wdog == WD_W'(TIMEOUT - 1));

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (i_start) w_next = (i_nonce_count == '0) ? S_FIN : S_ISSUE;
         S_ISSUE: w_next = S_WAIT;
         S_WAIT: begin
            if (hc.hc_rdy)  w_next = S_CHECK;
            else if (w_tmo) w_next = S_FIN;
         end
         S_CHECK: w_next = (w_hit || r_abort_pend || w_last) ? S_FIN : S_ISSUE;
         S_FIN:   w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         r_hdr        <= '0;
         r_target     <= '0;
         r_nonce      <= '0;
         r_count      <= '0;
         r_tried      <= '0;
         r_nonce_out  <= '0;
         r_digest     <= '0;
         r_din        <= '0;
         r_wdog       <= '0;
         r_found      <= 1'b0;
         r_tout       <= 1'b0;
         r_abort_pend <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: if (i_start) begin
               r_hdr        <= i_header[639:CNT_W];
               r_target     <= i_target;
               r_nonce      <= i_nonce_start;
               r_count      <= i_nonce_count;
               r_tried      <= '0;
               r_found      <= 1'b0;
               r_tout       <= 1'b0;
               r_abort_pend <= 1'b0;
               // din is loaded on entry to ISSUE so it is valid alongside hc_ena
               if (i_nonce_count != '0) r_din <= {i_header[639:CNT_W], i_nonce_start};
            end
            S_ISSUE: r_wdog <= '0;
            S_WAIT: begin
               r_wdog <= r_wdog + 1'b1;
               if (hc.hc_rdy) begin
                  r_digest    <= hc.hc_dout;
                  r_nonce_out <= r_nonce;
               end else if (w_tmo) begin
                  r_tout <= 1'b1;
               end
            end
            S_CHECK: begin
               r_tried <= w_tried_inc;
               if (w_hit) begin
                  r_found <= 1'b1;
               end else if (!(r_abort_pend || w_last)) begin
                  r_nonce <= w_nonce_inc;
                  r_din   <= {r_hdr, w_nonce_inc};
               end
            end
            default: ;
         endcase
         // abort arriving in FIN is dropped; the in-flight hash always completes
         if (i_abort && (r_state == S_ISSUE || r_state == S_WAIT || r_state == S_CHECK))
            r_abort_pend <= 1'b1;
      end
   end

   assign hc.hc_ena     = (r_state == S_ISSUE);
   assign hc.hc_din     = r_din;
   assign o_busy        = (r_state != S_IDLE);
   assign o_done        = (r_state == S_FIN);
   assign o_found       = r_found;
   assign o_timeout_err = r_tout;
   assign o_nonce_out   = r_nonce_out;
   assign o_digest_out  = r_digest;
   assign o_tried       = r_tried;

endmodule

// File: tb/tb_blake_nonce_scan.sv
// Bench for blake_nonce_scan: behavioural hash-core model plus a run-level scan model.
module tb_blake_nonce_scan;
   localparam int TIMEOUT = 200;

   logic clk = 1'b0;
   logic rstb = 1'b0;
   always #5 clk = ~clk;

   logic         start = 1'b0, abort = 1'b0;
   logic [639:0] header = '0;
   logic [31:0]  nonce_start = '0, nonce_count = '0;
   logic [511:0] target = '0;
   logic         busy, done, found, timeout_err;
   logic [31:0]  nonce_out, tried;
   logic [511:0] digest_out;

   blake_nonce_scan_if bus ();

   blake_nonce_scan #(.TIMEOUT(TIMEOUT), .CNT_W(32)) dut (
      .clk(clk), .rstb(rstb), .i_start(start), .i_abort(abort), .i_header(header),
      .i_nonce_start(nonce_start), .i_nonce_count(nonce_count), .i_target(target),
      .hc(bus), .o_busy(busy), .o_done(done), .o_found(found), .o_timeout_err(timeout_err),
      .o_nonce_out(nonce_out), .o_digest_out(digest_out), .o_tried(tried));

   int total = 0, bad = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [639:0] got, input logic [639:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endtask

   task automatic chk32(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endtask

   // stand-in digest: a deterministic scramble of nonce and header
   function automatic logic [511:0] dig(input logic [31:0] n, input logic [607:0] h);
      logic [511:0] d;
      logic [31:0]  w;
      for (int k = 0; k < 16; k++) begin
         w = (n ^ h[k*32 +: 32]) * 32'h9E3779B1 + 32'(k) * 32'h7F4A7C15;
         w = w ^ (w >> 15);
         w = w * 32'h85EBCA6B;
         d[k*32 +: 32] = w ^ (w >> 13);
      end
      return d;
   endfunction

   // core model controls and bookkeeping
   bit           core_silent = 0, dig_one = 0;
   int           core_lat = 0;
   int           ena_cnt = 0, last_ena_cyc = 0, last_rdy_cyc = -100;
   logic [639:0] cur_hdr = '0;
   logic [31:0]  exp_q[$];

   // run-level expectations
   bit           run_active = 0, done_seen = 0, exp_found = 0, exp_tout = 0, exp_chk_out = 0;
   logic [31:0]  exp_tried = '0, exp_nonce_out = '0;
   logic [511:0] exp_digest = '0;
   int           done_cyc = 0, st_cyc = 0;

   initial begin
      bit           cbusy;
      int           ccnt;
      logic [639:0] cdin;
      cbusy = 0; ccnt = 0; cdin = '0;
      bus.hc_rdy = 1'b0;
      bus.hc_dout = '0;
      forever begin
         @(negedge clk);
         if (!rstb) begin
            cbusy = 0;
            bus.hc_rdy = 1'b0;
            bus.hc_dout = '0;
         end else begin
            if (bus.hc_rdy) begin
               bus.hc_rdy = 1'b0;
               bus.hc_dout = '0;
            end
            if (bus.hc_ena) begin
               chk32("ena_core_idle", 32'(cbusy), 32'd0);
               chk32("ena_gap_after_rdy", 32'(cyc - last_rdy_cyc >= 2), 32'd1);
               ena_cnt++;
               last_ena_cyc = cyc;
               if (exp_q.size() == 0) chk32("unexpected_ena", 32'd1, 32'd0);
               else chk("hc_din", bus.hc_din, {cur_hdr[639:32], exp_q.pop_front()});
               cbusy = 1;
               cdin  = bus.hc_din;
               ccnt  = (core_lat != 0) ? core_lat : int'($urandom_range(2, 40));
            end else if (cbusy && !core_silent) begin
               ccnt--;
               if (ccnt == 0) begin
                  bus.hc_rdy  = 1'b1;
                  bus.hc_dout = dig_one ? 512'd1 : dig(cdin[31:0], cdin[639:32]);
                  cbusy = 0;
                  last_rdy_cyc = cyc;
               end
            end
         end
      end
   end

   // compare process
   initial forever begin
      @(negedge clk);
      #1;
      if (rstb) begin
         if (bus.hc_ena && bus.hc_rdy) chk32("ena_with_rdy", 32'd1, 32'd0);
         if (run_active) begin
            chk32("busy_in_run", 32'(busy), 32'd1);
            if (done) begin
               if (done_seen) chk32("double_done", 32'd1, 32'd0);
               done_seen = 1;
               done_cyc  = cyc;
               chk32("found", 32'(found), 32'(exp_found));
               chk32("timeout_err", 32'(timeout_err), 32'(exp_tout));
               chk32("tried", tried, exp_tried);
               chk32("issued_all", 32'(exp_q.size()), 32'd0);
               if (exp_chk_out) begin
                  chk32("nonce_out", nonce_out, exp_nonce_out);
                  chk("digest_out", 640'(digest_out), 640'(exp_digest));
               end
            end
         end else if (done) begin
            chk32("spurious_done", 32'd1, 32'd0);
         end
      end
   end

   // what a scan must do, from the rules: nonces in order, first digest < target wins
   task automatic model(input logic [31:0] ns, input logic [31:0] cnt, input logic [511:0] tg,
                        input logic [639:0] h, input int abort_k);
      logic [31:0]  n;
      logic [511:0] d;
      exp_q.delete();
      exp_found = 0; exp_tout = 0; exp_tried = '0; exp_chk_out = 0;
      if (core_silent) begin
         if (cnt != 0) begin
            exp_q.push_back(ns);
            exp_tout = 1;
         end
         return;
      end
      for (longint i = 0; i < longint'(cnt); i++) begin
         n = ns + 32'(i);
         d = dig_one ? 512'd1 : dig(n, h[639:32]);
         exp_q.push_back(n);
         exp_tried = 32'(i + 1);
         exp_nonce_out = n;
         exp_digest = d;
         exp_chk_out = 1;
         if (d < tg) begin
            exp_found = 1;
            break;
         end
         if (abort_k == int'(i) + 1) break;
      end
   endtask

   task automatic run(input logic [31:0] ns, input logic [31:0] cnt, input logic [511:0] tg,
                      input int abort_k, input int abort_dly, input bit spam);
      int base, k, budget;
      logic [639:0] h;
      for (int w = 0; w < 20; w++) h[w*32 +: 32] = $urandom;
      model(ns, cnt, tg, h, abort_k);
      budget = int'(cnt) * ((core_lat != 0) ? core_lat + 5 : 45) + TIMEOUT + 50;
      @(negedge clk);
      header = h; cur_hdr = h; nonce_start = ns; nonce_count = cnt; target = tg;
      start = 1'b1; st_cyc = cyc; base = ena_cnt;
      @(negedge clk);
      start = 1'b0; run_active = 1; done_seen = 0;
      header = {20{$urandom}}; nonce_start = $urandom; nonce_count = $urandom; target = '0;
      #2;
      k = 0;
      while (!done_seen && k < budget) begin
         abort = 1'b0;
         start = 1'b0;
         if (abort_k > 0 && ena_cnt - base == abort_k && cyc == last_ena_cyc + abort_dly)
            abort = 1'b1;
         if (spam && ena_cnt - base == 1 && cyc == last_ena_cyc + 1) begin
            start = 1'b1;
            nonce_start = $urandom;
            nonce_count = 32'd1;
         end
         @(negedge clk);
         #2;
         k++;
      end
      abort = 1'b0;
      start = 1'b0;
      if (!done_seen) chk32("done_within_budget", 32'd0, 32'd1);
      run_active = 0;
      @(negedge clk);
      #2;
      chk32("idle_after_done", {30'd0, busy, done}, 32'd0);
   endtask

   task automatic chk_zero(input string tag);
      chk(tag, {busy, done, found, timeout_err, nonce_out, tried, bus.hc_ena}, '0);
      chk({tag, "_digest"}, 640'(digest_out), '0);
      chk({tag, "_din"}, bus.hc_din, '0);
   endtask

   task automatic do_reset();
      run_active = 0;
      exp_q.delete();
      @(negedge clk);
      rstb = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      chk_zero("reset_outputs");
      rstb = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   initial begin
      int base, k, cnt, j, ak;
      logic [31:0]  ns;
      logic [511:0] tg;
      do_reset();

      // T1: constant digest 1, target all ones -> hit on the first nonce
      dig_one = 1; core_lat = 129; base = ena_cnt;
      run(32'h10, 32'd5, {512{1'b1}}, 0, 0, 0);
      chk32("t1_found", 32'(found), 32'd1);
      chk32("t1_nonce_out", nonce_out, 32'h10);
      chk32("t1_tried", tried, 32'd1);
      chk32("t1_ena_count", 32'(ena_cnt - base), 32'd1);
      chk("t1_digest", 640'(digest_out), 640'd1);
      chk32("t1_done_after_rdy", 32'(done_cyc - last_rdy_cyc), 32'd2);

      // digest equal to target is not a hit; one above it is
      run(32'h55, 32'd3, 512'd1, 0, 0, 0);
      chk32("eq_not_hit_found", 32'(found), 32'd0);
      chk32("eq_not_hit_tried", tried, 32'd3);
      run(32'h55, 32'd3, 512'd2, 0, 0, 0);
      chk32("above_hit_found", 32'(found), 32'd1);
      chk32("above_hit_tried", tried, 32'd1);

      // T2: target 0 never hits
      dig_one = 0; core_lat = 0;
      run(32'h100, 32'd3, '0, 0, 0, 0);
      chk32("t2_found", 32'(found), 32'd0);
      chk32("t2_tried", tried, 32'd3);
      chk32("t2_nonce_out", nonce_out, 32'h102);

      // T3: nonce wraps
      run(32'hFFFF_FFFF, 32'd2, '0, 0, 0, 0);
      chk32("t3_tried", tried, 32'd2);
      chk32("t3_nonce_out", nonce_out, 32'h0);

      // T4: silent core -> timeout
      core_silent = 1;
      run(32'h20, 32'd4, {512{1'b1}}, 0, 0, 0);
      chk32("t4_tout", 32'(timeout_err), 32'd1);
      chk32("t4_tried", tried, 32'd0);
      chk32("t4_done_after_wait_entry", 32'(done_cyc - (last_ena_cyc + 1)), 32'(TIMEOUT));
      core_silent = 0;
      do_reset();

      // T5: abort 50 cycles after the 2nd launch
      core_lat = 129; base = ena_cnt;
      run(32'h300, 32'd10, '0, 2, 50, 0);
      chk32("t5_tried", tried, 32'd2);
      chk32("t5_ena_count", 32'(ena_cnt - base), 32'd2);
      chk32("t5_done_after_rdy", 32'(done_cyc - last_rdy_cyc), 32'd2);

      // T6a: zero count
      core_lat = 0; base = ena_cnt;
      run(32'h40, 32'd0, {512{1'b1}}, 0, 0, 0);
      chk32("t6a_done_latency", 32'(done_cyc - st_cyc), 32'd1);
      chk32("t6a_no_ena", 32'(ena_cnt - base), 32'd0);
      chk32("t6a_tried", tried, 32'd0);

      // T6b: reset in the middle of WAIT
      core_lat = 60;
      exp_q.delete();
      exp_q.push_back(32'h7);
      @(negedge clk);
      header = {20{$urandom}}; cur_hdr = header; nonce_start = 32'h7; nonce_count = 32'd5;
      target = '0; start = 1'b1; base = ena_cnt;
      @(negedge clk);
      start = 1'b0;
      k = 0;
      while (ena_cnt == base && k < 20) begin @(negedge clk); k++; end
      chk32("t6b_launched", 32'(ena_cnt - base), 32'd1);
      repeat (10) @(negedge clk);
      rstb = 1'b0;
      #1;
      chk_zero("t6b_async_reset");
      repeat (2) @(negedge clk);
      rstb = 1'b1;
      exp_q.delete();
      @(negedge clk);
      core_lat = 0;
      run(32'h9, 32'd2, '0, 0, 0, 0);
      chk32("t6b_restart_tried", tried, 32'd2);

      // randomized scans
      for (int r = 0; r < 24; r++) begin
         cnt = int'($urandom_range(1, 8));
         ns  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF - $urandom_range(0, 4) : $urandom;
         j   = int'($urandom_range(0, cnt - 1));
         ak  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, cnt)) : 0;
         case ($urandom_range(0, 2))
            0: tg = '0;
            1: tg = {512{1'b1}};
            default: tg = {$urandom, 480'h0};
         endcase
         run(ns, 32'(cnt), tg, ak, 1, ($urandom_range(0, 2) == 0));
      end

      // targets pinned to a chosen nonce's digest (equal and one above), header fixed
      for (int r = 0; r < 6; r++) begin
         logic [639:0] h;
         for (int w = 0; w < 20; w++) h[w*32 +: 32] = $urandom;
         ns = $urandom; cnt = 4; j = r % 4;
         tg = dig(ns + 32'(j), h[639:32]) + 512'(r % 2);
         model(ns, 32'(cnt), tg, h, 0);
         @(negedge clk);
         header = h; cur_hdr = h; nonce_start = ns; nonce_count = 32'(cnt); target = tg;
         start = 1'b1; st_cyc = cyc;
         @(negedge clk);
         start = 1'b0; run_active = 1; done_seen = 0;
         k = 0;
         while (!done_seen && k < 400) begin @(negedge clk); #2; k++; end
         if (!done_seen) chk32("pinned_done_within_budget", 32'd0, 32'd1);
         run_active = 0;
         @(negedge clk);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL global_time_limit got=running exp=finished");
      $fatal(1, "time limit");
   end
endmodule
